// File: rtl/i2c_eeprom_counter_nv.sv
// i2c_eeprom_counter_nv: N-byte non-volatile counter kept in an I2C EEPROM.
// It restores the count at power-up, then updates it on inc/clr pulses and
// writes it back byte by byte, waiting out the EEPROM write cycle after each
// byte. I2C errors are retried per byte; when the retries run out the block
// parks in S_ERR until reset.
// Optional macro I2C_EEPROM_VERIFY_EN adds a read-back verify pass after
// every write sequence.
`timescale 1ns/1ps
module i2c_eeprom_counter_nv #(
    parameter int unsigned BYTE_NUM      = 2,
    parameter logic [15:0] BASE_ADDR     = 16'h0000,
    parameter bit          ADDR_2BYTE    = 1'b0,
    parameter logic [7:0]  DEV_ADDR      = 8'hA0,
    parameter int unsigned POWERUP_WAIT  = 499999,
    parameter int unsigned WR_CYCLE_WAIT = 249999,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  inc_pulse,
    input  logic                  clr_pulse,
    output logic                  i2c_read_req,
    input  logic                  i2c_read_req_ack,
    input  logic [7:0]            i2c_read_data,
    output logic                  i2c_write_req,
    input  logic                  i2c_write_req_ack,
    output logic [7:0]            i2c_write_data,
    output logic [7:0]            i2c_slave_dev_addr,
    output logic [15:0]           i2c_slave_reg_addr,
    output logic                  i2c_addr_2byte,
    input  logic                  i2c_error,
    output logic [8*BYTE_NUM-1:0] count_value,
    output logic                  count_valid,
    output logic                  busy,
    output logic                  err,
    output logic                  verify_err
);
    localparam int CW = 8 * BYTE_NUM;
    localparam logic [1:0] LAST_IDX = 2'(BYTE_NUM - 1);

    typedef enum logic [2:0] {
        S_POWERUP, S_RESTORE, S_IDLE, S_WRITE, S_WR_WAIT, S_ERR
`ifdef I2C_EEPROM_VERIFY_EN
        , S_VERIFY
`endif
    } state_t;

    state_t        state, state_n;
    logic [31:0]   timer, timer_n;
    logic [1:0]    idx, idx_n;
    logic [7:0]    retry, retry_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          valid, valid_n;
    logic          req, req_n;
    logic          pend_v, pend_v_n;
    logic          pend_c, pend_c_n;
    logic          busy_q, busy_n;
    logic          err_q, err_n;
`ifdef I2C_EEPROM_VERIFY_EN
    logic          verr, verr_n;
`endif

    logic          is_rd, is_wr, is_xfer, pend_window, got_ack, ack_ok;
    logic          eff_clr, eff_inc;
    logic [31:0]   cnt_ext, cnt_upd;
    logic [4:0]    sel;
    logic [7:0]    cur_byte;
    logic [15:0]   addr_full;

`ifdef I2C_EEPROM_VERIFY_EN
    assign is_rd       = (state == S_RESTORE) || (state == S_VERIFY);
    assign pend_window = (state == S_WRITE) || (state == S_WR_WAIT) ||
                         (state == S_VERIFY);
`else
    assign is_rd       = (state == S_RESTORE);
    assign pend_window = (state == S_WRITE) || (state == S_WR_WAIT);
`endif
    assign is_wr    = (state == S_WRITE);
    assign is_xfer  = is_rd || is_wr;
    assign got_ack  = req && ((is_rd && i2c_read_req_ack) ||
                              (is_wr && i2c_write_req_ack));
    assign ack_ok   = got_ack && !i2c_error;
    assign eff_clr  = clr_pulse || (pend_v && pend_c);
    assign eff_inc  = inc_pulse || (pend_v && !pend_c);
    assign cnt_ext  = 32'(cnt);
    assign sel      = {idx, 3'b000};
    assign cur_byte = cnt_ext[sel +: 8];
    assign addr_full = BASE_ADDR + {14'd0, idx};

    assign i2c_read_req       = req && is_rd;
    assign i2c_write_req      = req && is_wr;
    assign i2c_write_data     = is_wr ? cur_byte : 8'h00;
    assign i2c_slave_reg_addr = !is_xfer   ? 16'h0000 :
                                ADDR_2BYTE ? addr_full : {8'h00, addr_full[7:0]};
    assign i2c_slave_dev_addr = DEV_ADDR;
    assign i2c_addr_2byte     = ADDR_2BYTE;
    assign count_value        = cnt;
    assign count_valid        = valid;
    assign busy               = busy_q;
    assign err                = err_q;
`ifdef I2C_EEPROM_VERIFY_EN
    assign verify_err         = verr;
`else
    assign verify_err         = 1'b0;
`endif

    // State register: every piece of sequential state moves here together.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state  <= S_POWERUP;
            timer  <= '0;
            idx    <= '0;
            retry  <= '0;
            cnt    <= '0;
            valid  <= 1'b0;
            req    <= 1'b0;
            pend_v <= 1'b0;
            pend_c <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef I2C_EEPROM_VERIFY_EN
            verr   <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            idx    <= idx_n;
            retry  <= retry_n;
            cnt    <= cnt_n;
            valid  <= valid_n;
            req    <= req_n;
            pend_v <= pend_v_n;
            pend_c <= pend_c_n;
            busy_q <= busy_n;
            err_q  <= err_n;
`ifdef I2C_EEPROM_VERIFY_EN
            verr   <= verr_n;
`endif
        end
    end

    // Next-state logic: handshake, retry policy, pending pulse and sequencing.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        idx_n    = idx;
        retry_n  = retry;
        cnt_n    = cnt;
        valid_n  = valid;
        req_n    = req;
        pend_v_n = pend_v;
        pend_c_n = pend_c;
        cnt_upd  = cnt_ext;
`ifdef I2C_EEPROM_VERIFY_EN
        verr_n   = verr;
`endif
        if (is_xfer) begin
            if (got_ack)   req_n = 1'b0;
            else if (!req) req_n = 1'b1;
        end
        if (got_ack && i2c_error) begin
            if (retry == 8'(MAX_RETRY)) state_n = S_ERR;
            else                        retry_n = retry + 8'd1;
        end
        if (pend_window) begin
            if (clr_pulse) begin
                pend_v_n = 1'b1;
                pend_c_n = 1'b1;
            end else if (inc_pulse && !pend_v) begin
                pend_v_n = 1'b1;
                pend_c_n = 1'b0;
            end
        end
        case (state)
            S_POWERUP: begin
                if (timer == POWERUP_WAIT) begin
                    timer_n = '0;
                    idx_n   = '0;
                    retry_n = '0;
                    state_n = S_RESTORE;
                end else begin
                    timer_n = timer + 32'd1;
                end
            end
            S_RESTORE: begin
                if (ack_ok) begin
                    cnt_upd[sel +: 8] = i2c_read_data;
                    cnt_n   = cnt_upd[CW-1:0];
                    retry_n = '0;
                    if (idx == LAST_IDX) begin
                        valid_n = 1'b1;
                        idx_n   = '0;
                        state_n = S_IDLE;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
            end
            S_IDLE: begin
                pend_v_n = 1'b0;
                pend_c_n = 1'b0;
                if (eff_clr || eff_inc) begin
                    cnt_n   = eff_clr ? '0 : cnt + {{(CW-1){1'b0}}, 1'b1};
                    idx_n   = '0;
                    retry_n = '0;
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                if (ack_ok) begin
                    retry_n = '0;
                    timer_n = '0;
                    state_n = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (timer == WR_CYCLE_WAIT) begin
                    timer_n = '0;
                    if (idx == LAST_IDX) begin
                        idx_n = '0;
`ifdef I2C_EEPROM_VERIFY_EN
                        state_n = S_VERIFY;
`else
                        state_n = S_IDLE;
`endif
                    end else begin
                        idx_n   = idx + 2'd1;
                        state_n = S_WRITE;
                    end
                end else begin
                    timer_n = timer + 32'd1;
                end
            end
`ifdef I2C_EEPROM_VERIFY_EN
            S_VERIFY: begin
                if (ack_ok) begin
                    retry_n = '0;
                    if (i2c_read_data != cur_byte) verr_n = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_n   = '0;
                        state_n = S_IDLE;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
            end
`endif
            S_ERR: begin
                req_n = 1'b0;
            end
            default: begin
                state_n = S_ERR;
            end
        endcase
        busy_n = !((state_n == S_IDLE) || (state_n == S_ERR));
        err_n  = (state_n == S_ERR);
    end
endmodule

// File: tb/tb_i2c_eeprom_counter_nv.sv
// tb_i2c_eeprom_counter_nv: randomized bench for i2c_eeprom_counter_nv with
// a behavioural EEPROM/I2C-master model and a plain-arithmetic counter model.
// Honours I2C_EEPROM_VERIFY_EN when the design is built with it.
`timescale 1ns/1ps
module tb_i2c_eeprom_counter_nv;
    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inc_pulse = 1'b0, clr_pulse = 1'b0;
    logic        i2c_read_req, i2c_write_req;
    logic        i2c_read_req_ack = 1'b0, i2c_write_req_ack = 1'b0;
    logic [7:0]  i2c_read_data = 8'h00;
    logic [7:0]  i2c_write_data, i2c_slave_dev_addr;
    logic [15:0] i2c_slave_reg_addr;
    logic        i2c_addr_2byte;
    logic        i2c_error = 1'b0;
    logic [15:0] count_value;
    logic        count_valid, busy, err, verify_err;

    int checks = 0, failures = 0;
    int cyc = 0;
    int model = 0;
    logic [7:0] mem [256];
    int rdAddrQ[$], wrAddrQ[$], wrDataQ[$];
    int lat = 0, errBudget = 0, protoErr = 0;
    int lastRdAckCyc = 0, lastWrAckCyc = 0, minGap = 1000000;
    bit corrupt = 1'b0;

    i2c_eeprom_counter_nv #(
        .BYTE_NUM(2), .BASE_ADDR(16'h0000), .ADDR_2BYTE(1'b0),
        .DEV_ADDR(8'hA0), .POWERUP_WAIT(10), .WR_CYCLE_WAIT(5), .MAX_RETRY(3)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .inc_pulse(inc_pulse), .clr_pulse(clr_pulse),
        .i2c_read_req(i2c_read_req), .i2c_read_req_ack(i2c_read_req_ack),
        .i2c_read_data(i2c_read_data),
        .i2c_write_req(i2c_write_req), .i2c_write_req_ack(i2c_write_req_ack),
        .i2c_write_data(i2c_write_data),
        .i2c_slave_dev_addr(i2c_slave_dev_addr),
        .i2c_slave_reg_addr(i2c_slave_reg_addr),
        .i2c_addr_2byte(i2c_addr_2byte), .i2c_error(i2c_error),
        .count_value(count_value), .count_valid(count_valid),
        .busy(busy), .err(err), .verify_err(verify_err)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int memWord();
        return {16'h0000, mem[1], mem[0]};
    endfunction

    // EEPROM + I2C master model: acks after a random latency, injects errors,
    // and watches the handshake rules.
    initial begin : slave
        bit prevAck = 0, prevReq = 0;
        logic [15:0] prevAddr = 0;
        logic [7:0]  prevData = 0, prevCnt = 0;
        int a;
        forever begin
            @(negedge sys_clk);
            i2c_read_req_ack = 0; i2c_write_req_ack = 0; i2c_error = 0;
            if (!rst_n) begin
                lat = 0; prevAck = 0; prevReq = 0;
                continue;
            end
            if (i2c_read_req && i2c_write_req) protoErr++;
            if (prevAck && (i2c_read_req || i2c_write_req)) protoErr++;
            if ((i2c_read_req || i2c_write_req) && prevReq && !prevAck &&
                (i2c_slave_reg_addr != prevAddr || i2c_write_data != prevData ||
                 count_value[7:0] != prevCnt)) protoErr++;
            if ((i2c_read_req || i2c_write_req) &&
                (i2c_slave_dev_addr != 8'hA0 || i2c_slave_reg_addr[15:8] != 8'h00))
                protoErr++;
            prevReq  = i2c_read_req || i2c_write_req;
            prevAddr = i2c_slave_reg_addr;
            prevData = i2c_write_data;
            prevCnt  = count_value[7:0];
            if (prevReq && !prevAck) begin
                if (lat > 0) lat--;
                else begin
                    lat = $urandom_range(0, 3);
                    a = int'(i2c_slave_reg_addr[7:0]);
                    if (errBudget > 0) begin i2c_error = 1; errBudget--; end
                    if (i2c_read_req) begin
                        i2c_read_req_ack = 1;
                        i2c_read_data = (corrupt && a == 1) ? 8'hAA : mem[a];
                        if (!i2c_error) begin rdAddrQ.push_back(a); lastRdAckCyc = cyc; end
                    end else begin
                        i2c_write_req_ack = 1;
                        if (!busy) protoErr++;
                        if (!i2c_error) begin
                            mem[a] = i2c_write_data;
                            wrAddrQ.push_back(a); wrDataQ.push_back(int'(i2c_write_data));
                            if (a == 1 && cyc - lastWrAckCyc < minGap) minGap = cyc - lastWrAckCyc;
                            lastWrAckCyc = cyc;
                        end
                    end
                end
            end
            prevAck = i2c_read_req_ack || i2c_write_req_ack;
        end
    end

    task automatic applyStimulus(input bit inc, input bit clr, input bit onlyIfBusy,
                                 output bit applied);
        @(negedge sys_clk);
        applied = !(onlyIfBusy && !busy);
        if (applied) begin inc_pulse = inc; clr_pulse = clr; end
        @(negedge sys_clk);
        inc_pulse = 0; clr_pulse = 0;
    endtask

    task automatic modelApply(input bit inc, input bit clr);
        if (clr)      model = 0;
        else if (inc) model = (model + 1) & 16'hFFFF;
    endtask

    task automatic waitIdle();
        int lowCnt = 0;
        for (int n = 0; n < 400 && lowCnt < 2; n++) begin
            @(negedge sys_clk);
            lowCnt = busy ? 0 : lowCnt + 1;
        end
        if (lowCnt < 2) checkOutput("idle_timeout", 0, 1);
    endtask

    task automatic waitValid(output int seenCyc);
        seenCyc = -1;
        for (int n = 0; n < 300 && seenCyc < 0; n++) begin
            @(negedge sys_clk);
            if (count_valid) seenCyc = cyc;
        end
        if (seenCyc < 0) checkOutput("valid_timeout", 0, 1);
    endtask

    task automatic doReset();
        @(negedge sys_clk); rst_n = 0;
        repeat (2) @(negedge sys_clk);
        rst_n = 1;
    endtask

    task automatic presetAndRestore(input logic [15:0] v);
        int s;
        mem[0] = v[7:0]; mem[1] = v[15:8];
        doReset();
        waitValid(s);
        model = int'(v);
        rdAddrQ.delete(); wrAddrQ.delete(); wrDataQ.delete();
    endtask

    task automatic runSeq(input bit inc, input bit clr, input int nBusy, input bit rnd);
        bit applied, bi, bc;
        int pend = 0;
        applyStimulus(inc, clr, 0, applied);
        modelApply(inc, clr);
        for (int j = 0; j < nBusy; j++) begin
            bc = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            bi = !bc;
            applyStimulus(bi, bc, 1, applied);
            if (applied) begin
                if (bc) pend = 2;
                else if (pend == 0) pend = 1;
            end
        end
        waitIdle();
        if (pend == 2) modelApply(0, 1);
        else if (pend == 1) modelApply(1, 0);
    endtask

    task automatic checkCount(input string tag);
        checkOutput({tag, "_cnt"}, 32'(count_value), model);
        checkOutput({tag, "_mem"}, memWord(), model);
    endtask

    initial begin : main
        int s, reqSeen;
        bit applied;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h34; mem[1] = 8'h12;
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_rd_req", i2c_read_req, 0);
        checkOutput("rst_wr_req", i2c_write_req, 0);
        checkOutput("rst_count", 32'(count_value), 0);
        checkOutput("rst_valid", count_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_reg_addr", 32'(i2c_slave_reg_addr), 0);
        checkOutput("rst_wdata", 32'(i2c_write_data), 0);
        checkOutput("rst_dev_addr", 32'(i2c_slave_dev_addr), 32'h00A0);
        checkOutput("rst_addr_2byte", i2c_addr_2byte, 0);
        rst_n = 1;

        waitValid(s);
        checkOutput("restore_count", 32'(count_value), 32'h1234);
        checkOutput("restore_nreads", rdAddrQ.size(), 2);
        if (rdAddrQ.size() == 2) begin
            checkOutput("restore_addr0", rdAddrQ[0], 0);
            checkOutput("restore_addr1", rdAddrQ[1], 1);
        end
        checkOutput("valid_latency", s - lastRdAckCyc, 1);
        model = 32'h1234;
        waitIdle();
        checkCount("restore_idle");

        presetAndRestore(16'h00FF);
        runSeq(1, 0, 0, 0);
        checkCount("carry");
        checkOutput("carry_nwr", wrDataQ.size(), 2);
        if (wrDataQ.size() == 2) begin
            checkOutput("carry_wr0", {wrAddrQ[0][7:0], wrDataQ[0][7:0]}, 16'h0000);
            checkOutput("carry_wr1", {wrAddrQ[1][7:0], wrDataQ[1][7:0]}, 16'h0101);
        end

        presetAndRestore(16'hFFFF);
        runSeq(1, 0, 0, 0);
        checkCount("wrap");

        presetAndRestore(16'h0005);
        runSeq(1, 1, 0, 0);
        checkCount("clr_prio");

        runSeq(1, 0, 0, 0);
        runSeq(1, 0, 3, 0);
        checkCount("pending");

        for (int it = 0; it < 10; it++) begin
            int k = $urandom_range(0, 9);
            runSeq(k != 0, k <= 1, $urandom_range(0, 3), 1);
            checkCount($sformatf("rand%0d", it));
        end

`ifdef I2C_EEPROM_VERIFY_EN
        corrupt = 1;
        runSeq(1, 0, 0, 0);
        corrupt = 0;
        checkOutput("verify_err", verify_err, 1);
        checkCount("verify");
`else
        checkOutput("verify_err_tied", verify_err, 0);
`endif

        errBudget = 3;
        runSeq(1, 0, 0, 0);
        checkCount("retry_ok");
        checkOutput("retry_ok_err", err, 0);

        errBudget = 4;
        applyStimulus(1, 0, 0, applied);
        modelApply(1, 0);
        for (int n = 0; n < 200 && !err; n++) @(negedge sys_clk);
        checkOutput("err_set", err, 1);
        checkOutput("err_busy", busy, 0);
        reqSeen = 0;
        applyStimulus(1, 0, 0, applied);
        repeat (20) begin
            @(negedge sys_clk);
            if (i2c_read_req || i2c_write_req) reqSeen++;
        end
        checkOutput("err_no_req", reqSeen, 0);
        checkOutput("err_count_hold", 32'(count_value), model);

        doReset();
        waitValid(s);
        checkOutput("err_exit_restore", 32'(count_value), memWord());
        checkOutput("err_exit_flag", err, 0);
        model = memWord();
        waitIdle();
        applyStimulus(1, 0, 0, applied);
        for (int n = 0; n < 100 && !i2c_write_req; n++) @(negedge sys_clk);
        checkOutput("mid_wr_seen", i2c_write_req, 1);
        rst_n = 0;
        @(negedge sys_clk);
        checkOutput("mid_rst_rd_req", i2c_read_req, 0);
        checkOutput("mid_rst_wr_req", i2c_write_req, 0);
        rst_n = 1;
        waitValid(s);
        checkOutput("mid_rst_restore", 32'(count_value), memWord());

        checkOutput("protocol", protoErr, 0);
        checkOutput("wr_gap_ok", minGap >= 5, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
